// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag controller: drives the per-way tag memory for lookups, refills and flushes.
// Optional ICACHE_TAG_LFSR_REPL_EN selects LFSR victim choice instead of round-robin when a set is full.
module icache_tag_ctrl #(
    parameter int N_WAY      = 4,
    parameter int TAG_WIDTH  = 20,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lookup_valid_i,
    output logic                       lookup_ready_o,
    input  logic [ADDR_WIDTH-1:0]      lookup_idx_i,
    input  logic [TAG_WIDTH-1:0]       lookup_tag_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_hit_o,
    output logic [N_WAY-1:0]           rsp_way_o,
    input  logic                       refill_valid_i,
    input  logic [ADDR_WIDTH-1:0]      refill_idx_i,
    input  logic [TAG_WIDTH-1:0]       refill_tag_i,
    output logic                       refill_done_o,
    output logic [N_WAY-1:0]           refill_way_o,
    input  logic                       flush_i,
    output logic                       flush_busy_o,
    output logic [N_WAY-1:0]           tm_req_o,
    output logic                       tm_we_o,
    output logic                       tm_vbit_o,
    output logic                       tm_flush_o,
    output logic [ADDR_WIDTH-1:0]      tm_addr_o,
    output logic [TAG_WIDTH-1:0]       tm_data_o,
    input  logic [N_WAY*TAG_WIDTH-1:0] tm_tag_way_i,
    input  logic [N_WAY-1:0]           tm_vbit_i
);

    localparam int WAY_BITS = $clog2(N_WAY);

    typedef enum logic [2:0] {IDLE, LKP, RRD, RWR, FLS} state_t;

    state_t                  state, state_n;
    logic                    flush_pending;
    logic [TAG_WIDTH-1:0]    lkp_tag_q;
    logic [ADDR_WIDTH-1:0]   rf_idx_q;
    logic [TAG_WIDTH-1:0]    rf_tag_q;
    logic [N_WAY-1:0]        rf_vbit_q;
    logic                    start_lkp, start_rf, repl_adv;
    logic                    flush_req;
    logic [N_WAY-1:0]        hit_vec;
    logic [WAY_BITS-1:0]     repl_idx, victim_idx;
    logic [N_WAY-1:0]        victim_oh;
    logic                    all_valid;

`ifdef ICACHE_TAG_LFSR_REPL_EN
    logic [7:0] lfsr;
    assign repl_idx = lfsr[WAY_BITS-1:0];
`else
    logic [WAY_BITS-1:0] rr_ptr;
    assign repl_idx = rr_ptr;
`endif

    genvar g;
    generate
        for (g = 0; g < N_WAY; g++) begin : g_cmp
            assign hit_vec[g] = tm_vbit_i[g] &&
                                (tm_tag_way_i[g*TAG_WIDTH +: TAG_WIDTH] == lkp_tag_q);
        end
    endgenerate

    // Lowest-index invalid way wins; only a full set falls back to the replacement pointer.
    always_comb begin
        victim_idx = repl_idx;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!rf_vbit_q[i]) victim_idx = WAY_BITS'(i);
        end
        all_valid = &rf_vbit_q;
        victim_oh = {{(N_WAY-1){1'b0}}, 1'b1} << victim_idx;
    end

    assign flush_req    = flush_pending | flush_i;
    assign flush_busy_o = flush_pending | (state == FLS);
    assign rsp_hit_o    = |rsp_way_o;

    always_comb begin
        state_n        = state;
        lookup_ready_o = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_way_o      = '0;
        refill_done_o  = 1'b0;
        refill_way_o   = '0;
        tm_req_o       = '0;
        tm_we_o        = 1'b0;
        tm_vbit_o      = 1'b0;
        tm_flush_o     = 1'b0;
        tm_addr_o      = '0;
        tm_data_o      = '0;
        start_lkp      = 1'b0;
        start_rf       = 1'b0;
        repl_adv       = 1'b0;
        // Reset suppresses all memory traffic, so an in-flight refill write is dropped.
        if (!rst_i) begin
            case (state)
                IDLE, LKP: begin
                    if (state == LKP) begin
                        rsp_valid_o = 1'b1;
                        rsp_way_o   = hit_vec;
                    end
                    lookup_ready_o = !flush_req && !refill_valid_i;
                    if (flush_req) begin
                        state_n = FLS;
                    end else if (refill_valid_i) begin
                        tm_req_o  = '1;
                        tm_addr_o = refill_idx_i;
                        start_rf  = 1'b1;
                        state_n   = RRD;
                    end else if (lookup_valid_i) begin
                        tm_req_o  = '1;
                        tm_addr_o = lookup_idx_i;
                        start_lkp = 1'b1;
                        state_n   = LKP;
                    end else begin
                        state_n = IDLE;
                    end
                end
                RRD: state_n = RWR;
                RWR: begin
                    tm_req_o      = victim_oh;
                    tm_we_o       = 1'b1;
                    tm_vbit_o     = 1'b1;
                    tm_addr_o     = rf_idx_q;
                    tm_data_o     = rf_tag_q;
                    refill_done_o = 1'b1;
                    refill_way_o  = victim_oh;
                    repl_adv      = all_valid;
                    state_n       = flush_req ? FLS : IDLE;
                end
                FLS: begin
                    tm_flush_o = 1'b1;
                    tm_req_o   = '1;
                    state_n    = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            lkp_tag_q     <= '0;
            rf_idx_q      <= '0;
            rf_tag_q      <= '0;
            rf_vbit_q     <= '0;
`ifdef ICACHE_TAG_LFSR_REPL_EN
            lfsr          <= 8'h01;
`else
            rr_ptr        <= '0;
`endif
        end else begin
            state <= state_n;
            // A new flush request outranks the clear so back-to-back flushes are not lost.
            if (flush_i)
                flush_pending <= 1'b1;
            else if (state == FLS)
                flush_pending <= 1'b0;
            if (start_lkp) lkp_tag_q <= lookup_tag_i;
            if (start_rf) begin
                rf_idx_q <= refill_idx_i;
                rf_tag_q <= refill_tag_i;
            end
            if (state == RRD) rf_vbit_q <= tm_vbit_i;
            if (repl_adv) begin
`ifdef ICACHE_TAG_LFSR_REPL_EN
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
                rr_ptr <= rr_ptr + WAY_BITS'(1);
`endif
            end
        end
    end

endmodule
